// File: rtl/lite_nasti_read_arbiter_if.sv
// rtl/lite_nasti_read_arbiter_if.sv - upstream and downstream lite read channels of the arbiter
interface lite_nasti_read_arbiter_if #(
  parameter int N_MASTER   = 2,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int MIDX_W     = $clog2(N_MASTER)
);
  logic [N_MASTER*ID_WIDTH-1:0]   s_ar_id;
  logic [N_MASTER*ADDR_WIDTH-1:0] s_ar_addr;
  logic [N_MASTER*3-1:0]          s_ar_prot;
  logic [N_MASTER*USER_WIDTH-1:0] s_ar_user;
  logic [N_MASTER-1:0]            s_ar_valid;
  logic [N_MASTER-1:0]            s_ar_ready;

  logic [ID_WIDTH-1:0]            s_r_id;
  logic [DATA_WIDTH-1:0]          s_r_data;
  logic [1:0]                     s_r_resp;
  logic [USER_WIDTH-1:0]          s_r_user;
  logic [N_MASTER-1:0]            s_r_valid;
  logic [N_MASTER-1:0]            s_r_ready;

  logic [MIDX_W+ID_WIDTH-1:0]     m_ar_id;
  logic [ADDR_WIDTH-1:0]          m_ar_addr;
  logic [2:0]                     m_ar_prot;
  logic [USER_WIDTH-1:0]          m_ar_user;
  logic                           m_ar_valid;
  logic                           m_ar_ready;

  logic [MIDX_W+ID_WIDTH-1:0]     m_r_id;
  logic [DATA_WIDTH-1:0]          m_r_data;
  logic [1:0]                     m_r_resp;
  logic [USER_WIDTH-1:0]          m_r_user;
  logic                           m_r_valid;
  logic                           m_r_ready;

  logic                           route_err;

  modport slave (
    input  s_ar_id, s_ar_addr, s_ar_prot, s_ar_user, s_ar_valid,
    output s_ar_ready,
    output s_r_id, s_r_data, s_r_resp, s_r_user, s_r_valid,
    input  s_r_ready,
    output m_ar_id, m_ar_addr, m_ar_prot, m_ar_user, m_ar_valid,
    input  m_ar_ready,
    input  m_r_id, m_r_data, m_r_resp, m_r_user, m_r_valid,
    output m_r_ready,
    output route_err
  );

  modport master (
    output s_ar_id, s_ar_addr, s_ar_prot, s_ar_user, s_ar_valid,
    input  s_ar_ready,
    input  s_r_id, s_r_data, s_r_resp, s_r_user, s_r_valid,
    output s_r_ready,
    input  m_ar_id, m_ar_addr, m_ar_prot, m_ar_user, m_ar_valid,
    output m_ar_ready,
    output m_r_id, m_r_data, m_r_resp, m_r_user, m_r_valid,
    input  m_r_ready,
    input  route_err
  );
endinterface

// File: rtl/lite_nasti_read_arbiter.sv
// rtl/lite_nasti_read_arbiter.sv - round-robin AR arbiter with per-master outstanding limit and R routing
module lite_nasti_read_arbiter #(
  parameter int N_MASTER        = 2,
  parameter int ID_WIDTH        = 1,
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int USER_WIDTH      = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int MIDX_W          = $clog2(N_MASTER)
) (
  input  logic                      clk,
  input  logic                      rst,
  lite_nasti_read_arbiter_if.slave  bus
);
  localparam int                    CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [MIDX_W:0]       NM      = (MIDX_W + 1)'(N_MASTER);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state;
  logic [MIDX_W-1:0]   grant;
  logic [MIDX_W-1:0]   last_grant;
  logic [CNT_W-1:0]    cnt [N_MASTER];
  logic                route_err_q;

  logic [N_MASTER-1:0] elig;
  logic                pick_found;
  logic [MIDX_W-1:0]   pick;
  logic [MIDX_W:0]     cand;

  logic                  gvalid;
  logic [ID_WIDTH-1:0]   gid;
  logic [ADDR_WIDTH-1:0] gaddr;
  logic [2:0]            gprot;
  logic [USER_WIDTH-1:0] guser;
  logic                  ar_hs;

  logic [MIDX_W-1:0]   r_idx;
  logic                idx_ok;
  logic                sel_ready;
  logic                sel_zero;
  logic                r_hs;
  logic [N_MASTER-1:0] cnt_inc;
  logic [N_MASTER-1:0] cnt_dec;

  // Round-robin search starting one past the last accepted master.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      elig[i] = bus.s_ar_valid[i] && (cnt[i] < CNT_MAX);
    end
    for (int k = 1; k <= N_MASTER; k++) begin
      cand = {1'b0, last_grant} + (MIDX_W + 1)'(k);
      if (cand >= NM) begin
        cand = cand - NM;
      end
      if (!pick_found && elig[cand[MIDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick       = cand[MIDX_W-1:0];
      end
    end
  end

  always_comb begin
    gvalid = 1'b0;
    gid    = '0;
    gaddr  = '0;
    gprot  = '0;
    guser  = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (grant == MIDX_W'(i)) begin
        gvalid = bus.s_ar_valid[i];
        gid    = bus.s_ar_id[i*ID_WIDTH +: ID_WIDTH];
        gaddr  = bus.s_ar_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        gprot  = bus.s_ar_prot[i*3 +: 3];
        guser  = bus.s_ar_user[i*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  assign ar_hs          = (state == HOLD) && gvalid && bus.m_ar_ready;
  assign bus.m_ar_valid = (state == HOLD) && gvalid;
  assign bus.m_ar_id    = {grant, gid};
  assign bus.m_ar_addr  = gaddr;
  assign bus.m_ar_prot  = gprot;
  assign bus.m_ar_user  = guser;

  always_comb begin
    bus.s_ar_ready = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      bus.s_ar_ready[i] = (state == HOLD) && (grant == MIDX_W'(i)) && bus.m_ar_ready;
    end
  end

  assign r_idx = bus.m_r_id[MIDX_W+ID_WIDTH-1:ID_WIDTH];

  generate
    if (N_MASTER == (1 << MIDX_W)) begin : g_pow2
      assign idx_ok = 1'b1;
    end else begin : g_npow2
      assign idx_ok = (r_idx < MIDX_W'(N_MASTER));
    end
  endgenerate

  always_comb begin
    sel_ready     = 1'b0;
    sel_zero      = 1'b0;
    bus.s_r_valid = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (r_idx == MIDX_W'(i)) begin
        sel_ready        = bus.s_r_ready[i];
        sel_zero         = (cnt[i] == '0);
        bus.s_r_valid[i] = bus.m_r_valid;
      end
    end
  end

  // Out-of-range indices are sunk so the downstream never stalls on them.
  assign bus.m_r_ready = sel_ready || !idx_ok;
  assign r_hs          = bus.m_r_valid && sel_ready;
  assign bus.s_r_id    = bus.m_r_id[ID_WIDTH-1:0];
  assign bus.s_r_data  = bus.m_r_data;
  assign bus.s_r_resp  = bus.m_r_resp;
  assign bus.s_r_user  = bus.m_r_user;
  assign bus.route_err = route_err_q;

  always_comb begin
    for (int i = 0; i < N_MASTER; i++) begin
      cnt_inc[i] = ar_hs && (grant == MIDX_W'(i));
      cnt_dec[i] = r_hs && (r_idx == MIDX_W'(i)) && (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= MIDX_W'(N_MASTER - 1);
      route_err_q <= 1'b0;
      for (int i = 0; i < N_MASTER; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= pick;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (ar_hs) begin
            last_grant <= grant;
            state      <= IDLE;
          end else if (!gvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      for (int i = 0; i < N_MASTER; i++) begin
        if (cnt_inc[i] && !cnt_dec[i] && (cnt[i] != CNT_MAX)) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (cnt_dec[i] && !cnt_inc[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end

      // A response with nowhere to go, or for a master with nothing in flight.
      if ((bus.m_r_valid && !idx_ok) || (r_hs && sel_zero)) begin
        route_err_q <= 1'b1;
      end
    end
  end
endmodule
